// File: rtl/output_drain_scheduler.sv
// output_drain_scheduler: buffers tagged convolution results in a small
// show-ahead FIFO, drains them over valid/ready, throttles the controller
// through a registered stall and pulses done when a layer's last result pops.
// Optional build macro OUTPUT_DRAIN_STATS_EN adds saturating pop and
// backpressure counters (stat_drained, stat_backpressure).
module output_drain_scheduler #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STALL_MARGIN = 3
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic [31:0]                       in_x,
  input  logic [31:0]                       in_y,
  input  logic [31:0]                       in_ch,
  input  logic                              in_last,
  output logic                              stall,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [31:0]                       out_x,
  output logic [31:0]                       out_y,
  output logic [31:0]                       out_ch,
  output logic                              out_last,
  output logic [$clog2(FIFO_DEPTH):0]       level,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow
`ifdef OUTPUT_DRAIN_STATS_EN
  ,
  output logic [31:0]                       stat_drained,
  output logic [31:0]                       stat_backpressure
`endif
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STALL_TH = FIFO_DEPTH - STALL_MARGIN;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [31:0]           x;
    logic [31:0]           y;
    logic [31:0]           ch;
    logic                  last;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  entry_t             mem [FIFO_DEPTH];
  entry_t             head;
  entry_t             wr_entry;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level_next;
  state_t             state;
  state_t             state_next;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic               last_pop;

  // Show-ahead view of the head entry
  assign head      = mem[rd_ptr];
  assign out_valid = (level != '0);
  assign out_data  = head.data;
  assign out_x     = head.x;
  assign out_y     = head.y;
  assign out_ch    = head.ch;
  assign out_last  = head.last;
  assign wr_entry  = '{data: in_data, x: in_x, y: in_y, ch: in_ch, last: in_last};

  // Push/pop qualification and next occupancy
  always_comb begin
    full       = (level == LVL_W'(FIFO_DEPTH));
    pop        = out_valid && out_ready;
    push_ok    = in_valid && (!full || pop);
    drop       = in_valid && full && !pop;
    last_pop   = pop && head.last;
    level_next = level;
    if (push_ok && !pop) begin
      level_next = level + LVL_W'(1);
    end else if (!push_ok && pop) begin
      level_next = level - LVL_W'(1);
    end
  end

  // Layer tracking: a new last write arms TAIL, the last pop retires it
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (push_ok) state_next = in_last ? S_TAIL : S_RUN;
      end
      S_RUN: begin
        if (push_ok && in_last)                  state_next = S_TAIL;
        else if (last_pop && level_next == '0)   state_next = S_IDLE;
      end
      S_TAIL: begin
        if (last_pop) begin
          if (level_next == '0)                  state_next = S_IDLE;
          else if (push_ok && in_last)           state_next = S_TAIL;
          else                                   state_next = S_RUN;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Entry storage, cleared on reset and flush so the head reads zero
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers, occupancy, state and registered status outputs
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      state    <= S_IDLE;
      busy     <= 1'b0;
      stall    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      state    <= S_IDLE;
      busy     <= 1'b0;
      stall    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      level    <= level_next;
      state    <= state_next;
      busy     <= (state_next != S_IDLE);
      stall    <= (level_next >= LVL_W'(STALL_TH));
      done     <= last_pop;
      overflow <= overflow | drop;
    end
  end

`ifdef OUTPUT_DRAIN_STATS_EN
  // Saturating pop and backpressure counters
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      stat_drained      <= '0;
      stat_backpressure <= '0;
    end else if (flush) begin
      stat_drained      <= '0;
      stat_backpressure <= '0;
    end else begin
      if (pop && stat_drained != '1)
        stat_drained <= stat_drained + 32'd1;
      if (out_valid && !out_ready && stat_backpressure != '1)
        stat_backpressure <= stat_backpressure + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_output_drain_scheduler.sv
// Directed bench for output_drain_scheduler (DEPTH 8, MARGIN 3).
module tb_output_drain_scheduler;

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data, in_x, in_y, in_ch;
  logic        in_last;
  logic        stall, out_valid, out_ready;
  logic [31:0] out_data, out_x, out_y, out_ch;
  logic        out_last;
  logic [3:0]  level;
  logic        busy, done, overflow;
`ifdef OUTPUT_DRAIN_STATS_EN
  logic [31:0] stat_drained, stat_backpressure;
`endif

  int total = 0;
  int bad   = 0;

  output_drain_scheduler #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .STALL_MARGIN(3)) dut (
    .clk(clk), .arst_n_in(arst_n_in), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y),
    .in_ch(in_ch), .in_last(in_last), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_ch(out_ch), .out_last(out_last),
    .level(level), .busy(busy), .done(done), .overflow(overflow)
`ifdef OUTPUT_DRAIN_STATS_EN
    , .stat_drained(stat_drained), .stat_backpressure(stat_backpressure)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d, x, y, ch;
    logic        last, rdy, fl;
    logic [3:0]  e_lvl;
    logic        e_vld, e_stall, e_busy, e_done, e_ovf;
    logic        chk;
    logic [31:0] e_d, e_x, e_y, e_ch;
    logic        e_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic iv, input logic [31:0] d, x, y, ch, input logic last, rdy, fl,
    input logic [3:0] e_lvl, input logic e_vld, e_stall, e_busy, e_done, e_ovf,
    input logic chk, input logic [31:0] e_d, e_x, e_y, e_ch, input logic e_last);
    vec_t v;
    v.iv = iv; v.d = d; v.x = x; v.y = y; v.ch = ch; v.last = last;
    v.rdy = rdy; v.fl = fl; v.e_lvl = e_lvl; v.e_vld = e_vld;
    v.e_stall = e_stall; v.e_busy = e_busy; v.e_done = e_done; v.e_ovf = e_ovf;
    v.chk = chk; v.e_d = e_d; v.e_x = e_x; v.e_y = e_y; v.e_ch = e_ch;
    v.e_last = e_last;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, x, y, ch,
                       input logic last, rdy, fl);
    in_valid = iv; in_data = d; in_x = x; in_y = y; in_ch = ch;
    in_last = last; out_ready = rdy; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q_d[$];
    logic [31:0] q_x[$];
    int          pops;
    logic [31:0] a_base;

    arst_n_in = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    arst_n_in = 1'b1;

    // Reset state
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", out_data, 32'd0);

    // Single result, backpressure, full push+pop, overflow, flush in TAIL
    vecs.push_back(mk(1, 'h11, 2, 3, 4, 1, 1, 0, 1, 1, 0, 1, 0, 0, 1, 'h11, 2, 3, 4, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    a_base = 32'hA0;
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, a_base + 32'(i), 0, 0, 0, 0, 0, 0, 4'(i + 1), 1,
                        (i + 1 >= 5), 1, 0, 0, 1, 'hA0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'hB0, 0, 0, 0, 0, 1, 0, 8, 1, 1, 1, 0, 0, 1, 'hA1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'hA8, 0, 0, 0, 0, 0, 0, 8, 1, 1, 1, 0, 1, 1, 'hA1, 0, 0, 0, 0));
    for (int j = 0; j < 4; j++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 4'(7 - j), 1, (7 - j >= 5), 1, 0, 1,
                        1, 32'hA2 + 32'(j), 0, 0, 0, 0));
    vecs.push_back(mk(1, 'hC0, 0, 0, 0, 1, 0, 0, 5, 1, 1, 1, 0, 1, 1, 'hA5, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'hD0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].x, vecs[i].y, vecs[i].ch,
            vecs[i].last, vecs[i].rdy, vecs[i].fl);
      tick();
      chk($sformatf("r%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
      chk($sformatf("r%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
      chk($sformatf("r%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("r%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("r%0d_done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("r%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      if (vecs[i].chk) begin
        chk($sformatf("r%0d_data", i), out_data, vecs[i].e_d);
        chk($sformatf("r%0d_x", i), out_x, vecs[i].e_x);
        chk($sformatf("r%0d_y", i), out_y, vecs[i].e_y);
        chk($sformatf("r%0d_ch", i), out_ch, vecs[i].e_ch);
        chk($sformatf("r%0d_last", i), 32'(out_last), 32'(vecs[i].e_last));
      end
    end

    // Wrap-around: 20 writes interleaved with pops, pointers wrap twice
    pops = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        drive(1'b1, 32'h100 + 32'(k / 2), 32'(k / 2), 32'(k), 32'(k / 2 + 7),
              (k / 2 == 19), 1'b0, 1'b0);
        q_d.push_back(32'h100 + 32'(k / 2));
        q_x.push_back(32'(k / 2));
      end else begin
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk($sformatf("wrap%0d_valid", k), 32'(out_valid), 32'd1);
        if (out_valid && q_d.size() > 0) begin
          chk($sformatf("wrap%0d_data", k), out_data, q_d.pop_front());
          chk($sformatf("wrap%0d_x", k), out_x, q_x.pop_front());
          pops++;
        end
      end
      tick();
      chk($sformatf("wrap%0d_stall", k), 32'(stall), 32'd0);
    end
    chk("wrap_pops", 32'(pops), 32'd20);
    chk("wrap_level", 32'(level), 32'd0);
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_busy", 32'(busy), 32'd0);
    chk("wrap_ovf", 32'(overflow), 32'd0);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wrap_done_clr", 32'(done), 32'd0);

    // Asynchronous reset mid-operation discards contents at once
    drive(1'b1, 32'h55, 1, 1, 1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("pre_arst_level", 32'(level), 32'd2);
    #2;
    arst_n_in = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", out_data, 32'd0);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    arst_n_in = 1'b1;

`ifdef OUTPUT_DRAIN_STATS_EN
    // 6 pops and 4 backpressured cycles
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 32'(c), '0, '0, '0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("stat_drained", stat_drained, 32'd6);
    chk("stat_backpressure", stat_backpressure, 32'd4);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("stat_drained_flush", stat_drained, 32'd0);
    chk("stat_bp_flush", stat_backpressure, 32'd0);
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
